// File: rtl/sram_access_ctrl.sv
// Access sequencer for the sram_compiled_array macro: one request at a time,
// generating setup / write-pulse / hold / sense phases and a single response.
module sram_access_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_write_en,
  output logic              sram_sense_en,
  input  logic [DATA_W-1:0] sram_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    SENSE = 3'd4,
    RESP  = 3'd5
  } state_e;

  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_we_q, op_we_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                write_en_q, write_en_d;
  logic                sense_en_q, sense_en_d;
  logic                accept;

  assign accept = req_valid && req_ready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = op_we_q ? WRITE : SENSE;
      WRITE:   if (cnt_q == 4'd0) state_d = HOLD;
      HOLD:    state_d = RESP;
      SENSE:   if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SENSE opens with one address-settle cycle (counter loaded with RD_CYCLES,
  // sense low), then holds sense_en for RD_CYCLES; dout is captured as it drops.
  always_comb begin
    cnt_d      = cnt_q;
    op_we_d    = op_we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rdata_d    = rdata_q;
    sense_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          op_we_d = req_we;
          if (req_we) din_d = req_wdata;
        end
      end
      SETUP: cnt_d = op_we_q ? WR_LOAD : RD_LOAD;
      WRITE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      SENSE: begin
        if (cnt_q != 4'd0) begin
          cnt_d      = cnt_q - 4'd1;
          sense_en_d = 1'b1;
        end else begin
          rdata_d = sram_dout;
        end
      end
      default: ;
    endcase
    write_en_d  = (state_d == WRITE);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= 4'd0;
      op_we_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      write_en_q  <= 1'b0;
      sense_en_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      write_en_q  <= write_en_d;
      sense_en_q  <= sense_en_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_din      = din_q;
  assign sram_write_en = write_en_q;
  assign sram_sense_en = sense_en_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: default-parameter instance [0] and a
// WR_CYCLES=3/RD_CYCLES=3 instance [1], each backed by a behavioural array.
module tb_sram_access_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid     [2];
  logic        req_ready     [2];
  logic        req_we        [2];
  logic [11:0] req_addr      [2];
  logic [7:0]  req_wdata     [2];
  logic        rsp_valid     [2];
  logic        rsp_ready     [2];
  logic [7:0]  rsp_rdata     [2];
  logic [11:0] sram_addr     [2];
  logic [7:0]  sram_din      [2];
  logic        sram_write_en [2];
  logic        sram_sense_en [2];
  logic [7:0]  sram_dout     [2];

  logic [7:0]  mem     [2][4096];
  logic [7:0]  exp_mem [2][4096];
  logic [7:0]  exp_last [2];
  int          wr_cyc [2];
  int          rd_cyc [2];
  logic [7:0]  sb_q [$];

  int n_assert;
  int n_fail;
  bit mon_en;
  bit          acc_m [2];
  logic [11:0] pa_m  [2];
  logic [7:0]  pd_m  [2];

  sram_access_ctrl #(.ADDR_W(12), .DATA_W(8), .WR_CYCLES(2), .RD_CYCLES(1)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_din(sram_din[0]),
    .sram_write_en(sram_write_en[0]), .sram_sense_en(sram_sense_en[0]),
    .sram_dout(sram_dout[0])
  );

  sram_access_ctrl #(.ADDR_W(12), .DATA_W(8), .WR_CYCLES(3), .RD_CYCLES(3)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_din(sram_din[1]),
    .sram_write_en(sram_write_en[1]), .sram_sense_en(sram_sense_en[1]),
    .sram_dout(sram_dout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: writes land while write_en is high, dout is only
  // meaningful while sense_en is high.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (sram_write_en[d] === 1'b1) mem[d][sram_addr[d]] <= sram_din[d];
  end
  assign sram_dout[0] = (sram_sense_en[0] === 1'b1) ? mem[0][sram_addr[0]] : 8'hEE;
  assign sram_dout[1] = (sram_sense_en[1] === 1'b1) ? mem[1][sram_addr[1]] : 8'hEE;

  // Continuous protocol monitor: exclusive enables, address/data only move on accept.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      acc_m[d] = (req_valid[d] === 1'b1) && (req_ready[d] === 1'b1);
      pa_m[d]  = sram_addr[d];
      pd_m[d]  = sram_din[d];
    end
  end

  always @(negedge clk) begin
    if (mon_en && resetn === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        n_assert++;
        if ((sram_write_en[d] && sram_sense_en[d]) !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_enables_excl dut%0d: we=%b se=%b required not both high", d, sram_write_en[d], sram_sense_en[d]);
        end
        n_assert++;
        if (!acc_m[d] && (sram_addr[d] !== pa_m[d] || sram_din[d] !== pd_m[d])) begin
          n_fail++;
          $display("FAIL mon_addr_din_stable dut%0d: addr %h din %h, required %h %h", d, sram_addr[d], sram_din[d], pa_m[d], pd_m[d]);
        end
      end
    end
  end

  task automatic do_req(input int d, input bit we, input logic [11:0] addr,
                        input logic [7:0] wdata, input int stall, input string tag);
    int          cyc;
    int          lat;
    logic [31:0] we_tr, se_tr, we_exp, se_exp;
    logic [7:0]  d0, exp_rd, rd_hold;
    bit          stable_ok, busy_ok, bp_ok;
    cyc = we ? wr_cyc[d] : rd_cyc[d];
    @(negedge clk);
    n_assert++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_idle: req_ready=%b required 1", tag, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    d0 = we ? wdata : sram_din[d];
    if (we) begin
      exp_rd = exp_last[d];
      exp_mem[d][addr] = wdata;
    end else begin
      exp_rd = exp_mem[d][addr];
      exp_last[d] = exp_rd;
    end
    sb_q.push_back(exp_rd);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = ~addr; req_wdata[d] = ~wdata;
    we_tr = '0; se_tr = '0; lat = -1; stable_ok = 1'b1; busy_ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      we_tr[k] = sram_write_en[d];
      se_tr[k] = sram_sense_en[d];
      if (sram_addr[d] !== addr || sram_din[d] !== d0) stable_ok = 1'b0;
      if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
      if (rsp_valid[d] === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    n_assert++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL %s_timeout: no rsp_valid within 32 cycles", tag);
      void'(sb_q.pop_front());
      return;
    end
    we_exp = '0; se_exp = '0;
    if (we) for (int k = 1; k <= cyc; k++) we_exp[k] = 1'b1;
    else    for (int k = 2; k <= cyc + 1; k++) se_exp[k] = 1'b1;
    n_assert++;
    if (lat != 2 + cyc) begin
      n_fail++;
      $display("FAIL %s_latency: rsp after E%0d required E%0d", tag, lat, 2 + cyc);
    end
    n_assert++;
    if (we_tr !== we_exp) begin
      n_fail++;
      $display("FAIL %s_write_en_trace: %b required %b", tag, we_tr, we_exp);
    end
    n_assert++;
    if (se_tr !== se_exp) begin
      n_fail++;
      $display("FAIL %s_sense_en_trace: %b required %b", tag, se_tr, se_exp);
    end
    n_assert++;
    if (!stable_ok) begin
      n_fail++;
      $display("FAIL %s_addr_din: addr/din moved, final %h %h required %h %h", tag, sram_addr[d], sram_din[d], addr, d0);
    end
    n_assert++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL %s_ready_busy: req_ready high during operation, required 0", tag);
    end
    rd_hold = rsp_rdata[d];
    bp_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 12'h055; req_wdata[d] = 8'hFF;
      end
      @(posedge clk); #1;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd_hold || req_ready[d] !== 1'b0) bp_ok = 1'b0;
      if (s == stall - 1) req_valid[d] = 1'b0;
    end
    if (stall > 0) begin
      n_assert++;
      if (!bp_ok) begin
        n_fail++;
        $display("FAIL %s_backpressure: rsp_valid=%b rdata=%h req_ready=%b required 1 %h 0", tag, rsp_valid[d], rsp_rdata[d], req_ready[d], rd_hold);
      end
    end
    exp_rd = sb_q.pop_front();
    n_assert++;
    if (rsp_rdata[d] !== exp_rd) begin
      n_fail++;
      $display("FAIL %s_rdata: got %h required %h", tag, rsp_rdata[d], exp_rd);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    n_assert++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handshake: rsp_valid=%b req_ready=%b required 0 1", tag, rsp_valid[d], req_ready[d]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 8'h00 ||
          sram_addr[d] !== 12'h000 || sram_din[d] !== 8'h00 ||
          sram_write_en[d] !== 1'b0 || sram_sense_en[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: rdy=%b vld=%b rdata=%h addr=%h din=%h we=%b se=%b required 1 0 00 000 00 0 0",
                 tag, d, req_ready[d], rsp_valid[d], rsp_rdata[d], sram_addr[d], sram_din[d],
                 sram_write_en[d], sram_sense_en[d]);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #23;
    check_reset_values("reset_values");
    @(negedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_reset_values("after_release");
    mon_en = 1'b1;
  endtask

  task automatic test_write_default();
    do_req(0, 1'b1, 12'h123, 8'hA5, 0, "wr_123");
  endtask

  task automatic test_read_default();
    do_req(0, 1'b0, 12'h123, 8'h00, 0, "rd_123");
    do_req(0, 1'b1, 12'hFFF, 8'h3C, 0, "wr_fff");
    do_req(0, 1'b1, 12'h000, 8'h81, 0, "wr_000");
    do_req(0, 1'b0, 12'hFFF, 8'h00, 0, "rd_fff");
    do_req(0, 1'b0, 12'h000, 8'h00, 0, "rd_000");
  endtask

  task automatic test_backpressure();
    do_req(0, 1'b1, 12'h055, 8'h11, 0, "wr_055");
    do_req(0, 1'b0, 12'hFFF, 8'h00, 5, "bp_rd");
    do_req(0, 1'b0, 12'h055, 8'h00, 0, "after_bp");
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 12'h2AA; req_wdata[0] = 8'h5A;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sram_write_en[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_assert++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_mid_wait: write_en never rose, required 1");
    end
    #2 resetn = 1'b0;
    #1;
    n_assert++;
    if (sram_write_en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_we: write_en=%b required 0 before any edge", sram_write_en[0]);
    end
    check_reset_values("rst_mid_values");
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    @(negedge clk); #2;
    resetn = 1'b1;
    n_assert++;
    if (req_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: req_ready=%b required 1", req_ready[0]);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0 || sram_write_en[0] !== 1'b0) seen = 1'b1;
    end
    n_assert++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_mid_no_rsp: rsp_valid or write_en rose after abort, required 0");
    end
  endtask

  task automatic test_nondefault();
    do_req(1, 1'b1, 12'h7E5, 8'hC3, 0, "nd_wr_7e5");
    do_req(1, 1'b0, 12'h7E5, 8'h00, 0, "nd_rd_7e5");
    do_req(1, 1'b1, 12'hFFF, 8'h6D, 0, "nd_wr_fff");
    do_req(1, 1'b0, 12'hFFF, 8'h00, 2, "nd_rd_fff");
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = 12'($urandom_range(256, 4095));
      do_req(0, 1'b1, a[i], 8'($urandom_range(0, 255)), 0, "b2b_wr");
    end
    for (int i = 3; i >= 0; i--) do_req(0, 1'b0, a[i], 8'h00, 0, "b2b_rd");
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    wr_cyc[0] = 2; rd_cyc[0] = 1;
    wr_cyc[1] = 3; rd_cyc[1] = 3;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      rsp_ready[d] = 1'b0; exp_last[d] = 8'h00;
    end
    test_reset();
    test_write_default();
    test_read_default();
    test_backpressure();
    test_reset_mid_write();
    test_nondefault();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
